crypto_sched: RTL and testbench

CRYPTO_SCHED -- requirements
Module: crypto_sched

---
 rtl/crypto_pkg.sv | 17 +
 rtl/crypto_rr_arb.sv | 25 ++
 rtl/crypto_sched.sv | 115 +++++++++++
 tb/tb_crypto_sched.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/crypto_pkg.sv
// Shared types and constants for the crypto command scheduler.
package crypto_pkg;
  localparam int NUM_REQ = 2;
  localparam int BLK_W   = 128;

  localparam logic ALGO_AES = 1'b0;
  localparam logic ALGO_SM4 = 1'b1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  // Command captured at the request handshake and held for the engine.
  typedef struct packed {
    logic             algo;
    logic [BLK_W-1:0] key;
    logic [BLK_W-1:0] din;
  } cmd_t;
endpackage

// File: rtl/crypto_rr_arb.sv
// Two-way round-robin grant: pointer requester wins if valid, else the other.
module crypto_rr_arb
  import crypto_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               accept,
  output logic               gnt_idx,
  output logic               gnt_vld
);
  logic ptr;

  // Winner selection from the current pointer.
  always_comb begin
    gnt_idx = req[ptr] ? ptr : ~ptr;
    gnt_vld = |req;
  end

  // On an accepted grant the pointer moves to the requester that lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         ptr <= 1'b0;
    else if (accept) ptr <= ~gnt_idx;
  end
endmodule

// File: rtl/crypto_sched.sv
// Crypto scheduler: arbitrates two requesters onto one AES/SM4 engine,
// one transaction in flight. Optional WAIT timeout abort is compiled in
// with CRYPTO_SCHED_TIMEOUT_EN.
module crypto_sched
  import crypto_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_algo,
  input  logic [NUM_REQ-1:0][BLK_W-1:0] req_key,
  input  logic [NUM_REQ-1:0][BLK_W-1:0] req_din,
  output logic [NUM_REQ-1:0]            rsp_valid,
  input  logic [NUM_REQ-1:0]            rsp_ready,
  output logic [BLK_W-1:0]              rsp_data,
  output logic                          rsp_err,
  output logic                          eng_start,
  output logic                          eng_algo_sel,
  output logic [BLK_W-1:0]              eng_key,
  output logic [BLK_W-1:0]              eng_din,
  input  logic                          eng_done,
  input  logic                          eng_busy,
  input  logic [BLK_W-1:0]              eng_dout
);
  state_t state;
  logic   g_q;
  cmd_t   cmd;
  logic   gnt;
  logic   gnt_vld;
  logic   accept;

  crypto_rr_arb u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .accept  (accept),
    .gnt_idx (gnt),
    .gnt_vld (gnt_vld)
  );

  // Ready only toward the granted requester while idle; rsp_valid only in RESP.
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    if (state == IDLE && gnt_vld && !rst) req_ready[gnt] = 1'b1;
    if (state == RESP)                    rsp_valid[g_q] = 1'b1;
  end

  assign accept       = |(req_valid & req_ready);
  assign eng_algo_sel = cmd.algo;
  assign eng_key      = cmd.key;
  assign eng_din      = cmd.din;

`ifdef CRYPTO_SCHED_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_cnt;
  logic             rsp_err_q;
  assign rsp_err = rsp_err_q;
`else
  // Timeout disabled: folds to constant 0.
  assign rsp_err = (TIMEOUT_CYC < 0);
`endif

  // Transaction FSM; operands stay in cmd until the next accepted request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      g_q       <= 1'b0;
      cmd       <= '0;
      eng_start <= 1'b0;
      rsp_data  <= '0;
`ifdef CRYPTO_SCHED_TIMEOUT_EN
      tmo_cnt   <= '0;
      rsp_err_q <= 1'b0;
`endif
    end else begin
      eng_start <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          g_q   <= gnt;
          cmd   <= '{algo: req_algo[gnt], key: req_key[gnt], din: req_din[gnt]};
          state <= ISSUE;
        end
        ISSUE: if (!eng_busy) begin
          eng_start <= 1'b1;
          state     <= WAIT;
`ifdef CRYPTO_SCHED_TIMEOUT_EN
          tmo_cnt   <= '0;
`endif
        end
        WAIT: if (eng_done) begin
          rsp_data  <= eng_dout;
`ifdef CRYPTO_SCHED_TIMEOUT_EN
          rsp_err_q <= 1'b0;
`endif
          state     <= RESP;
        end
`ifdef CRYPTO_SCHED_TIMEOUT_EN
        else if (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
          rsp_data  <= '0;
          rsp_err_q <= 1'b1;
          state     <= RESP;
        end else begin
          tmo_cnt   <= tmo_cnt + 1'b1;
        end
`endif
        RESP: if (rsp_ready[g_q]) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_crypto_sched.sv
// Bench for crypto_sched: stand-in engine, round-robin reference model,
// directed steps with randomized operands and engine latencies.
module tb_crypto_sched;
  import crypto_pkg::*;

  localparam int TMO = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [1:0]        req_valid = '0;
  logic [1:0]        req_ready;
  logic [1:0]        req_algo = '0;
  logic [1:0][127:0] req_key = '0;
  logic [1:0][127:0] req_din = '0;
  logic [1:0]        rsp_valid;
  logic [1:0]        rsp_ready = '0;
  logic [127:0]      rsp_data;
  logic              rsp_err;
  logic              eng_start, eng_algo_sel;
  logic [127:0]      eng_key, eng_din;
  logic              eng_done = 1'b0;
  logic              eng_busy = 1'b0;
  logic [127:0]      eng_dout = '0;

  crypto_sched #(.TIMEOUT_CYC(TMO)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_algo     (req_algo),
    .req_key      (req_key),
    .req_din      (req_din),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_err      (rsp_err),
    .eng_start    (eng_start),
    .eng_algo_sel (eng_algo_sel),
    .eng_key      (eng_key),
    .eng_din      (eng_din),
    .eng_done     (eng_done),
    .eng_busy     (eng_busy),
    .eng_dout     (eng_dout)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int m_ptr = 0;
  int eng_lat = 2;
  bit eng_mute = 1'b0;
  int n_start = 0;
  bit op_moved = 1'b0;
  bit overlap = 1'b0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Stand-in engine: known test vectors, otherwise a simple mixing function.
  function automatic logic [127:0] eng_fn(input logic a, input logic [127:0] k, input logic [127:0] d);
    if (a == ALGO_SM4 && k == 128'h0123456789abcdeffedcba9876543210 && d == k)
      return 128'h681edf34d206965e86b3e94f536e4246;
    if (a == ALGO_AES && k == 128'h2b7e151628aed2a6abf7158809cf4f3c &&
        d == 128'h6bc1bee22e409f96e93d7e117393172a)
      return 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    return {k[63:0], k[127:64]} ^ d ^ {128{a}};
  endfunction

  // Engine model: eng_done appears eng_lat cycles after the start pulse.
  logic         e_algo;
  logic [127:0] e_key, e_din;
  bit           eng_act = 1'b0;
  int           eng_cnt = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      eng_done <= 1'b0;
      eng_act  <= 1'b0;
      eng_cnt  <= 0;
    end else begin
      eng_done <= 1'b0;
      if (eng_start) begin
        n_start <= n_start + 1;
        e_algo  <= eng_algo_sel;
        e_key   <= eng_key;
        e_din   <= eng_din;
        if (eng_lat <= 1) begin
          eng_done <= !eng_mute;
          eng_dout <= eng_fn(eng_algo_sel, eng_key, eng_din);
        end else begin
          eng_act <= 1'b1;
          eng_cnt <= eng_lat - 1;
        end
      end else if (eng_act) begin
        if ({eng_algo_sel, eng_key, eng_din} != {e_algo, e_key, e_din}) op_moved <= 1'b1;
        if (eng_cnt <= 1) begin
          eng_act  <= 1'b0;
          eng_done <= !eng_mute;
          eng_dout <= eng_fn(e_algo, e_key, e_din);
        end else begin
          eng_cnt <= eng_cnt - 1;
        end
      end
    end
  end

  // req_ready and rsp_valid must never be high together.
  always @(negedge clk) if (|req_ready && |rsp_valid) overlap <= 1'b1;

  task automatic randomize_req(input int j);
    req_algo[j] = 1'($urandom_range(0, 1));
    req_key[j]  = {$urandom, $urandom, $urandom, $urandom};
    req_din[j]  = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_data"}, rsp_data, 0);
    chk({tag, "_rsp_err"}, rsp_err, 0);
    chk({tag, "_eng_start"}, eng_start, 0);
    chk({tag, "_eng_algo"}, eng_algo_sel, 0);
    chk({tag, "_eng_key"}, eng_key, 0);
    chk({tag, "_eng_din"}, eng_din, 0);
  endtask

  // One full transaction; called at a negedge with the scheduler idle.
  task automatic txn(input logic [1:0] vld, input bit hold, input int busy_c,
                     input int stall_c, input int lat);
    int w, n, s0, exp_n;
    logic [1:0] oh;
    logic [127:0] exp_d;
    eng_lat   = lat;
    req_valid = vld;
    #1;
    w     = vld[m_ptr] ? m_ptr : 1 - m_ptr;
    oh    = 2'(1 << w);
    exp_d = eng_mute ? 128'h0 : eng_fn(req_algo[w], req_key[w], req_din[w]);
    exp_n = eng_mute ? 2 + TMO : lat + 3 + busy_c;
    n = 0;
    while (req_ready == 2'b00 && n < 50) begin @(negedge clk); n++; end
    chk("grant", req_ready, oh);
    s0    = n_start;
    m_ptr = 1 - w;
    if (busy_c > 0) eng_busy = 1'b1;
    @(negedge clk);
    n = 1;
    if (!hold) req_valid = '0;
    while (rsp_valid == 2'b00 && n < 200) begin
      if (busy_c > 0 && n <= busy_c + 1) chk("start_while_busy", eng_start, 0);
      if (n == busy_c + 1) eng_busy = 1'b0;
      @(negedge clk);
      n++;
    end
    chk("rsp_latency", n, exp_n);
    chk("rsp_valid", rsp_valid, oh);
    chk("rsp_data", rsp_data, exp_d);
    chk("rsp_err", rsp_err, eng_mute);
    chk("eng_algo", eng_algo_sel, req_algo[w]);
    chk("eng_key", eng_key, req_key[w]);
    chk("eng_din", eng_din, req_din[w]);
    chk("one_start", n_start - s0, 1);
    for (int i = 0; i < stall_c; i++) begin
      rsp_ready = (i == 0) ? ~oh : 2'b00;
      @(negedge clk);
      chk("stall_rsp_valid", rsp_valid, oh);
      chk("stall_rsp_data", rsp_data, exp_d);
      chk("stall_req_ready", req_ready, 0);
      chk("stall_eng_start", eng_start, 0);
    end
    rsp_ready = oh;
    @(negedge clk);
    rsp_ready = '0;
    chk("rsp_drop", rsp_valid, 0);
  endtask

  initial begin
    int n;
    // Reset state, with requests already pending.
    req_valid = 2'b11;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    req_valid = '0;
    rst = 1'b0;
    m_ptr = 0;
    @(negedge clk);

    // Requester 0 alone, SM4 vector.
    req_algo[0] = ALGO_SM4;
    req_key[0]  = 128'h0123456789abcdeffedcba9876543210;
    req_din[0]  = 128'h0123456789abcdeffedcba9876543210;
    txn(2'b01, 1'b0, 0, 0, 3);

    // Requester 1 alone, AES vector.
    req_algo[1] = ALGO_AES;
    req_key[1]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    req_din[1]  = 128'h6bc1bee22e409f96e93d7e117393172a;
    txn(2'b10, 1'b0, 0, 0, 1);

    // Both valid continuously after reset; one transaction stalls on rsp_ready.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_ptr = 0;
    for (int i = 0; i < 4; i++) begin
      randomize_req(0);
      randomize_req(1);
      txn(2'b11, 1'b1, 0, (i == 2) ? 10 : 0, $urandom_range(1, 6));
    end
    req_valid = '0;

    // Engine busy for 5 cycles on entering ISSUE.
    randomize_req(0);
    txn(2'b01, 1'b0, 5, 0, 2);

    // Random mix of requesters, latencies and busy windows.
    for (int i = 0; i < 8; i++) begin
      logic [1:0] v;
      v = 2'($urandom_range(1, 3));
      randomize_req(0);
      randomize_req(1);
      txn(v, 1'b0, $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(1, 8));
    end

`ifdef CRYPTO_SCHED_TIMEOUT_EN
    // Suppressed eng_done: abort with rsp_err after TMO WAIT cycles.
    eng_mute = 1'b1;
    randomize_req(1);
    txn(2'b10, 1'b0, 0, 2, 3);
    eng_mute = 1'b0;
`endif

    // Reset in WAIT: no response, pointer back to 0.
    randomize_req(0);
    eng_lat   = 30;
    req_valid = 2'b01;
    #1;
    n = 0;
    while (req_ready == 2'b00 && n < 50) begin @(negedge clk); n++; end
    chk("mid_grant", req_ready, 2'b01);
    m_ptr = 1;
    @(negedge clk);
    req_valid = '0;
    repeat (5) @(negedge clk);
    chk("mid_eng_key", eng_key, req_key[0]);
    rst = 1'b1;
    #1;
    chk_all_zero("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    m_ptr = 0;
    repeat (40) begin
      @(negedge clk);
      if (rsp_valid != 2'b00) break;
    end
    chk("mid_no_rsp", rsp_valid, 0);
    randomize_req(0);
    randomize_req(1);
    txn(2'b11, 1'b0, 0, 0, 2);

    chk("no_ready_with_rsp", overlap, 0);
    chk("operands_stable", op_moved, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
